// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth partial-product accumulator.
// Takes one encoded row per input handshake, weights it by 4^k for row k,
// sums the rows into a 2*WIDTH-bit product and holds the result on a
// valid/ready output until it is consumed.
//
// Handshake semantics (both ports): a transfer happens at a rising edge
// where valid and ready are both high. in_ready is high only while
// accepting rows, and out_valid is high only while a product is held, so
// the input and output phases never overlap. A held product stays stable
// until out_ready or abort. abort overrides both handshakes in its cycle.
module booth_pp_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_pp,
  input  logic                 in_s,
  input  logic                 in_p,
  input  logic                 in_unsign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_unsign
);

  localparam int ROWS  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(ROWS);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     acc;
  logic              row_fire;

  logic [WIDTH+2:0]  row_v;
  logic [PW-1:0]     row_ext;
  logic [PW-1:0]     contrib;
  logic [PW-1:0]     acc_sum;

  // Row value: a negative row (in_p=0) is in_pp - 2^(WIDTH+1), which is the
  // same bit pattern as in_pp with ones prepended; the +in_s correction
  // needs one more bit of headroom, hence WIDTH+3 bits.
  assign row_v   = {(in_p ? 2'b00 : 2'b11), in_pp} + {{(WIDTH+2){1'b0}}, in_s};
  assign row_ext = {{(PW-WIDTH-3){row_v[WIDTH+2]}}, row_v};
  assign contrib = row_ext << {cnt, 1'b0};
  // Row 0 starts a fresh sum so no stale accumulator state leaks in.
  assign acc_sum = (cnt == '0) ? contrib : acc + contrib;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; abort wins over every handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    row_fire  = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        row_fire = in_valid;
        if (in_valid && (cnt == LAST_ROW)) begin
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
    if (abort) begin
      state_nxt = ST_ACC;
      row_fire  = 1'b0;
    end
  end

  // Accumulator, row counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      out_product <= '0;
      out_unsign  <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
      acc <= '0;
    end else if (row_fire) begin
      acc <= acc_sum;
      if (cnt == '0) begin
        out_unsign <= in_unsign;
      end
      if (cnt == LAST_ROW) begin
        cnt         <= '0;
        out_product <= acc_sum;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
